bp_me_io_cmd_arbiter: RTL and testbench

Shares one host-side I/O command/response channel between `num_req_p` loader requesters, e.g. the CCE config loader and the NBF loader, each speaking `bp_cce_mem_msg_s`. It grants one requester command per cycle onto the link and records the winner's index in an order FIFO. Because the link returns responses in order, each response is routed back to the requester at the FIFO head. It sits between the loaders and `bp_me_cce_to_mem_link_bidir`, and replaces the fixed cfg/nbf mux in the top-level benches.

---
 rtl/bp_me_pkg.sv | 35 +++
 rtl/bp_me_io_arb_order_fifo.sv | 60 ++++++
 rtl/bp_me_io_cmd_arbiter.sv | 100 ++++++++++
 tb/tb_bp_me_io_cmd_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Memory-engine shared types: the CCE memory message and I/O arbiter helpers.
// Imported by bp_me_io_cmd_arbiter and its order FIFO.
package bp_me_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [3:0] {
        e_mem_msg_rd    = 4'd0,
        e_mem_msg_wr    = 4'd1,
        e_mem_msg_uc_rd = 4'd2,
        e_mem_msg_uc_wr = 4'd3
    } bp_mem_msg_e;

    typedef struct packed {
        bp_mem_msg_e  msg_type;
        logic [2:0]   size;
        logic [39:0]  addr;
        logic [63:0]  data;
    } bp_cce_mem_msg_s;

    // Message width for a given configuration.
    function automatic int bp_me_msg_width(input bp_params_e cfg);
        case (cfg)
            default: return $bits(bp_cce_mem_msg_s);
        endcase
    endfunction

    // Requester-index width, never below one bit.
    function automatic int bp_me_io_arb_id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/bp_me_io_arb_order_fifo.sv
// Order FIFO of requester ids for in-flight I/O commands.
// Pointers wrap modulo depth_p; count runs 0..depth_p.
module bp_me_io_arb_order_fifo #(
    parameter int depth_p = 8,
    parameter int id_w_p  = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [id_w_p-1:0] id_i,
    input  logic              pop_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [id_w_p-1:0] head_id_o
);

    localparam int ptr_w_lp = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int cnt_w_lp = $clog2(depth_p + 1);

    logic [id_w_p-1:0]   mem_q [depth_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;

    function automatic logic [ptr_w_lp-1:0] wrap_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(depth_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o    = (cnt_q == cnt_w_lp'(depth_p));
    assign empty_o   = (cnt_q == '0);
    assign head_id_o = mem_q[rptr_q];

    // Next pointers and count from this cycle's push/pop.
    always_comb begin
        wptr_d = push_i ? wrap_inc(wptr_q) : wptr_q;
        rptr_d = pop_i  ? wrap_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q + cnt_w_lp'(push_i) - cnt_w_lp'(pop_i);
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Id storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= id_i;
        end
    end

endmodule

// File: rtl/bp_me_io_cmd_arbiter.sv
// Shares one I/O command/response link among num_req_p loaders.
// Define BP_IO_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module bp_me_io_cmd_arbiter
    import bp_me_pkg::*;
#(
    parameter bp_params_e bp_params_p       = e_bp_default_cfg,
    parameter int         num_req_p         = 2,
    parameter int         max_outstanding_p = 8,
    localparam int        msg_w_lp          = bp_me_msg_width(bp_params_p)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_req_p-1:0][msg_w_lp-1:0] io_cmd_i,
    input  logic [num_req_p-1:0]               io_cmd_v_i,
    output logic [num_req_p-1:0]               io_cmd_yumi_o,
    output logic [msg_w_lp-1:0]                io_resp_o,
    output logic [num_req_p-1:0]               io_resp_v_o,
    input  logic [num_req_p-1:0]               io_resp_ready_i,
    output logic [msg_w_lp-1:0]                mem_cmd_o,
    output logic                               mem_cmd_v_o,
    input  logic                               mem_cmd_ready_i,
    input  logic [msg_w_lp-1:0]                mem_resp_i,
    input  logic                               mem_resp_v_i,
    output logic                               mem_resp_yumi_o
);

    localparam int id_w_lp = bp_me_io_arb_id_width(num_req_p);

    logic                 fifo_full, fifo_empty;
    logic [id_w_lp-1:0]   head_id, grant_id, prio_ptr;
    logic [num_req_p-1:0] elig;
    logic                 cmd_fire;
    int                   scan_idx;

    assign elig = io_cmd_v_i & {num_req_p{~fifo_full & ~reset_i}};

    // Pointer-rotated priority encoder: first eligible from prio_ptr upward.
    always_comb begin
        grant_id    = '0;
        mem_cmd_v_o = 1'b0;
        scan_idx    = 0;
        for (int k = 0; k < num_req_p; k++) begin
            scan_idx = (int'(prio_ptr) + k) % num_req_p;
            if (!mem_cmd_v_o && elig[scan_idx]) begin
                mem_cmd_v_o = 1'b1;
                grant_id    = id_w_lp'(scan_idx);
            end
        end
    end

    assign mem_cmd_o = io_cmd_i[grant_id];
    assign cmd_fire  = mem_cmd_v_o & mem_cmd_ready_i;

    // One-hot accept to the winner.
    always_comb begin
        io_cmd_yumi_o           = '0;
        io_cmd_yumi_o[grant_id] = cmd_fire;
    end

    // Route link response to the requester at the FIFO head.
    always_comb begin
        io_resp_v_o          = '0;
        io_resp_v_o[head_id] = mem_resp_v_i & ~fifo_empty & ~reset_i;
    end

    assign io_resp_o       = mem_resp_i;
    assign mem_resp_yumi_o = io_resp_v_o[head_id] & io_resp_ready_i[head_id];

`ifdef BP_IO_ARB_ROUND_ROBIN_EN
    logic [id_w_lp-1:0] prio_ptr_q;

    // Advance past the winner only when its command is accepted.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_ptr_q <= '0;
        end else if (cmd_fire) begin
            prio_ptr_q <= (grant_id == id_w_lp'(num_req_p - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    assign prio_ptr = prio_ptr_q;
`else
    assign prio_ptr = '0;
`endif

    bp_me_io_arb_order_fifo #(
        .depth_p (max_outstanding_p),
        .id_w_p  (id_w_lp)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .push_i    (cmd_fire),
        .id_i      (grant_id),
        .pop_i     (mem_resp_yumi_o),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_id_o (head_id)
    );

endmodule

// File: tb/tb_bp_me_io_cmd_arbiter.sv
// Directed bench for bp_me_io_cmd_arbiter (2 requesters, depth 8).
// Expectations follow BP_IO_ARB_ROUND_ROBIN_EN when it is defined.
module tb_bp_me_io_cmd_arbiter;
    import bp_me_pkg::*;

    localparam int W = $bits(bp_cce_mem_msg_s);

    logic               clk = 1'b0;
    logic               reset_i;
    logic [1:0][W-1:0]  io_cmd_i;
    logic [1:0]         io_cmd_v_i;
    logic [1:0]         io_cmd_yumi_o;
    logic [W-1:0]       io_resp_o;
    logic [1:0]         io_resp_v_o;
    logic [1:0]         io_resp_ready_i;
    logic [W-1:0]       mem_cmd_o;
    logic               mem_cmd_v_o;
    logic               mem_cmd_ready_i;
    logic [W-1:0]       mem_resp_i;
    logic               mem_resp_v_i;
    logic               mem_resp_yumi_o;

    bp_cce_mem_msg_s cmd0, cmd1, rsp;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bp_me_io_cmd_arbiter #(
        .num_req_p         (2),
        .max_outstanding_p (8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .io_cmd_i        (io_cmd_i),
        .io_cmd_v_i      (io_cmd_v_i),
        .io_cmd_yumi_o   (io_cmd_yumi_o),
        .io_resp_o       (io_resp_o),
        .io_resp_v_o     (io_resp_v_o),
        .io_resp_ready_i (io_resp_ready_i),
        .mem_cmd_o       (mem_cmd_o),
        .mem_cmd_v_o     (mem_cmd_v_o),
        .mem_cmd_ready_i (mem_cmd_ready_i),
        .mem_resp_i      (mem_resp_i),
        .mem_resp_v_i    (mem_resp_v_i),
        .mem_resp_yumi_o (mem_resp_yumi_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        io_cmd_v_i      = 2'b00;
        io_resp_ready_i = 2'b11;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_i         = 1'b1;
        io_cmd_v_i      = 2'b11;
        io_resp_ready_i = 2'b11;
        mem_cmd_ready_i = 1'b1;
        mem_resp_v_i    = 1'b1;
        #1;
        checks++;
        if ({mem_cmd_v_o, io_cmd_yumi_o, io_resp_v_o, mem_resp_yumi_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000000",
                     {mem_cmd_v_o, io_cmd_yumi_o, io_resp_v_o, mem_resp_yumi_o});
        end
        tick();
        reset_i = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (dut.u_fifo.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d want=0", dut.u_fifo.cnt_q);
        end
    endtask

    task automatic test_single();
        io_cmd_v_i = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (io_cmd_yumi_o !== 2'b01 || mem_cmd_o !== W'(cmd0)) begin
                errors++;
                $display("FAIL single_issue%0d yumi=%b want=01", c, io_cmd_yumi_o);
            end
            tick();
        end
        io_cmd_v_i = 2'b00;
        #1;
        checks++;
        if (dut.u_fifo.cnt_q !== 4'd3) begin
            errors++;
            $display("FAIL single_cnt3 got=%0d want=3", dut.u_fifo.cnt_q);
        end
        mem_resp_v_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (io_resp_v_o !== 2'b01 || mem_resp_yumi_o !== 1'b1 || io_resp_o !== W'(rsp)) begin
                errors++;
                $display("FAIL single_resp%0d resp_v=%b yumi=%b want=01/1",
                         c, io_resp_v_o, mem_resp_yumi_o);
            end
            tick();
        end
        #1;
        checks++;
        if (dut.u_fifo.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL single_cnt0 got=%0d want=0", dut.u_fifo.cnt_q);
        end
        checks++;
        if (mem_resp_yumi_o !== 1'b0 || io_resp_v_o !== 2'b00) begin
            errors++;
            $display("FAIL empty_resp yumi=%b resp_v=%b want=0/00", mem_resp_yumi_o, io_resp_v_o);
        end
        mem_resp_v_i = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0] want [6];
        pulse_reset();
        for (int c = 0; c < 6; c++) begin
`ifdef BP_IO_ARB_ROUND_ROBIN_EN
            want[c] = (c % 2 == 0) ? 2'b01 : 2'b10;
`else
            want[c] = 2'b01;
`endif
        end
        io_cmd_v_i = 2'b11;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (io_cmd_yumi_o !== want[c]) begin
                errors++;
                $display("FAIL contend_grant%0d got=%b want=%b", c, io_cmd_yumi_o, want[c]);
            end
            tick();
        end
        io_cmd_v_i   = 2'b00;
        mem_resp_v_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (io_resp_v_o !== want[c] || mem_resp_yumi_o !== 1'b1) begin
                errors++;
                $display("FAIL contend_resp%0d got=%b want=%b", c, io_resp_v_o, want[c]);
            end
            tick();
        end
        mem_resp_v_i = 1'b0;
    endtask

    task automatic test_full();
        pulse_reset();
        io_cmd_v_i = 2'b01;
        for (int c = 0; c < 8; c++) tick();
        #1;
        checks++;
        if (mem_cmd_v_o !== 1'b0 || io_cmd_yumi_o !== 2'b00 || dut.u_fifo.cnt_q !== 4'd8) begin
            errors++;
            $display("FAIL full_block v=%b yumi=%b cnt=%0d want=0/00/8",
                     mem_cmd_v_o, io_cmd_yumi_o, dut.u_fifo.cnt_q);
        end
        mem_resp_v_i = 1'b1;
        #1;
        checks++;
        if (mem_resp_yumi_o !== 1'b1 || mem_cmd_v_o !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_block yumi=%b cmd_v=%b want=1/0", mem_resp_yumi_o, mem_cmd_v_o);
        end
        tick();
        mem_resp_v_i = 1'b0;
        #1;
        checks++;
        if (mem_cmd_v_o !== 1'b1 || io_cmd_yumi_o !== 2'b01) begin
            errors++;
            $display("FAIL full_next_accept v=%b yumi=%b want=1/01", mem_cmd_v_o, io_cmd_yumi_o);
        end
        tick();
        io_cmd_v_i   = 2'b00;
        mem_resp_v_i = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        mem_resp_v_i = 1'b0;
        #1;
        checks++;
        if (dut.u_fifo.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL full_drain got=%0d want=0", dut.u_fifo.cnt_q);
        end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        io_cmd_v_i      = 2'b10;
        mem_cmd_ready_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (mem_cmd_v_o !== 1'b1 || io_cmd_yumi_o !== 2'b00 || mem_cmd_o !== W'(cmd1)) begin
                errors++;
                $display("FAIL bp_stall%0d v=%b yumi=%b want=1/00", c, mem_cmd_v_o, io_cmd_yumi_o);
            end
            tick();
        end
        checks++;
        if (dut.prio_ptr !== 1'b0 || dut.u_fifo.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL bp_ptr ptr=%b cnt=%0d want=0/0", dut.prio_ptr, dut.u_fifo.cnt_q);
        end
        mem_cmd_ready_i = 1'b1;
        #1;
        checks++;
        if (io_cmd_yumi_o !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got=%b want=10", io_cmd_yumi_o);
        end
        tick();
        io_cmd_v_i      = 2'b00;
        io_resp_ready_i = 2'b01;
        mem_resp_v_i    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (io_resp_v_o !== 2'b10 || mem_resp_yumi_o !== 1'b0) begin
                errors++;
                $display("FAIL bp_resp_hold%0d v=%b yumi=%b want=10/0", c, io_resp_v_o, mem_resp_yumi_o);
            end
            tick();
        end
        io_resp_ready_i = 2'b11;
        #1;
        checks++;
        if (mem_resp_yumi_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_resp_go got=%b want=1", mem_resp_yumi_o);
        end
        tick();
        mem_resp_v_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        io_cmd_v_i = 2'b01;
        for (int c = 0; c < 5; c++) tick();
        io_cmd_v_i = 2'b00;
        #1;
        checks++;
        if (dut.u_fifo.cnt_q !== 4'd5) begin
            errors++;
            $display("FAIL mid_cnt5 got=%0d want=5", dut.u_fifo.cnt_q);
        end
        reset_i      = 1'b1;
        io_cmd_v_i   = 2'b11;
        mem_resp_v_i = 1'b1;
        #1;
        checks++;
        if ({mem_cmd_v_o, io_cmd_yumi_o, io_resp_v_o, mem_resp_yumi_o} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%b want=000000",
                     {mem_cmd_v_o, io_cmd_yumi_o, io_resp_v_o, mem_resp_yumi_o});
        end
        tick();
        reset_i    = 1'b0;
        io_cmd_v_i = 2'b00;
        #1;
        checks++;
        if (dut.u_fifo.cnt_q !== 4'd0) begin
            errors++;
            $display("FAIL mid_cnt0 got=%0d want=0", dut.u_fifo.cnt_q);
        end
        checks++;
        if (mem_resp_yumi_o !== 1'b0 || io_resp_v_o !== 2'b00) begin
            errors++;
            $display("FAIL mid_late_resp yumi=%b v=%b want=0/00", mem_resp_yumi_o, io_resp_v_o);
        end
        mem_resp_v_i = 1'b0;
    endtask

    initial begin
        cmd0 = '{msg_type: e_mem_msg_uc_wr, size: 3'd3, addr: 40'h10_0000, data: 64'h1111};
        cmd1 = '{msg_type: e_mem_msg_uc_rd, size: 3'd2, addr: 40'h20_0040, data: 64'h2222};
        rsp  = '{msg_type: e_mem_msg_uc_rd, size: 3'd3, addr: 40'h30_0080, data: 64'hCAFE};
        io_cmd_i   = {W'(cmd1), W'(cmd0)};
        mem_resp_i = W'(rsp);
        test_reset();
        test_single();
        test_contention();
        test_full();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
